// File: rtl/cordic_angle_reducer_if.sv
// Handshake and data bundle for cordic_angle_reducer: input vector side and reduced output side.
// slave is the reducer's view of the bundle; master is the driving/consuming environment's view.
interface cordic_angle_reducer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic [WIDTH-1:0] in_angle;

    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_mode;
    logic [WIDTH-1:0] out_x;
    logic [WIDTH-1:0] out_y;
    logic [WIDTH-1:0] out_angle;
    logic             out_flip;
    logic             out_err;

    modport slave (
        input  in_valid, in_mode, in_x, in_y, in_angle, out_ready,
        output in_ready, out_valid, out_mode, out_x, out_y, out_angle, out_flip, out_err
    );

    modport master (
        output in_valid, in_mode, in_x, in_y, in_angle, out_ready,
        input  in_ready, out_valid, out_mode, out_x, out_y, out_angle, out_flip, out_err
    );
endinterface

// File: rtl/cordic_angle_reducer.sv
// Angle reducer feeding CORDIC_Rotation: folds circular-mode angles into [-pi/2, +pi/2].
// Optional linear z range check enabled by defining CORDIC_LINEAR_RANGE_CHECK_EN.
module cordic_angle_reducer #(
    parameter int WIDTH     = 32,
    parameter int RED_STEPS = 13,
    parameter int PI_Q      = 205887,
    parameter int HALF_PI_Q = 102944,
    parameter int ONE_Q     = 65536
) (
    input logic clock,
    input logic reset_n,
    cordic_angle_reducer_if.slave bus
);
    localparam int RW = 48;
    localparam int KW = $clog2(RED_STEPS + 1);
    localparam logic [1:0] MODE_CIRCULAR = 2'b00;
    localparam logic signed [RW-1:0] PI_R      = RW'(PI_Q);
    localparam logic signed [RW-1:0] TWO_PI_R  = RW'(2 * PI_Q);
    localparam logic signed [RW-1:0] HALF_PI_R = RW'(HALF_PI_Q);
`ifdef CORDIC_LINEAR_RANGE_CHECK_EN
    localparam logic signed [RW-1:0] ONE_R     = RW'(ONE_Q);
`endif

    typedef enum logic [2:0] {IDLE, REDUCE, FOLD, QUAD, LCHK, DONE} state_t;

    state_t state, state_nx;

    logic signed [RW-1:0] r;
    logic signed [RW-1:0] step;
    logic signed [RW-1:0] sr;
    logic signed [RW-1:0] ang_ext;
    logic                 neg;
    logic [KW-1:0]        k;
    logic [1:0]           mode_w;
    logic [WIDTH-1:0]     x_w, y_w;

    logic [1:0]           mode_q;
    logic [WIDTH-1:0]     x_q, y_q, ang_q;
    logic                 flip_q, err_q;
    logic                 in_ready_c, out_valid_c;

    function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] v);
        if (v == {1'b1, {(WIDTH-1){1'b0}}})
            return {1'b0, {(WIDTH-1){1'b1}}};
        return -v;
    endfunction

    // r holds |angle| through REDUCE; the sign lives in neg so |-2^WIDTH-1| stays exact
    assign ang_ext = RW'(signed'(bus.in_angle));
    assign step    = TWO_PI_R <<< k;
    assign sr      = neg ? -r : r;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid)
                    state_nx = (bus.in_mode == MODE_CIRCULAR) ? REDUCE : LCHK;
            end
            REDUCE:  if (k == '0) state_nx = FOLD;
            FOLD:    state_nx = QUAD;
            QUAD:    state_nx = DONE;
            LCHK:    state_nx = DONE;
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r      <= '0;
            neg    <= 1'b0;
            k      <= '0;
            mode_w <= '0;
            x_w    <= '0;
            y_w    <= '0;
            mode_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
            ang_q  <= '0;
            flip_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    x_w    <= bus.in_x;
                    y_w    <= bus.in_y;
                    mode_w <= bus.in_mode;
                    neg    <= bus.in_angle[WIDTH-1];
                    r      <= bus.in_angle[WIDTH-1] ? -ang_ext : ang_ext;
                    k      <= KW'(RED_STEPS - 1);
                end
                REDUCE: begin
                    if (r >= step) r <= r - step;
                    if (k != '0) k <= k - 1'b1;
                end
                FOLD: begin
                    if (sr > PI_R)        r <= sr - TWO_PI_R;
                    else if (sr <= -PI_R) r <= sr + TWO_PI_R;
                    else                  r <= sr;
                end
                QUAD: begin
                    mode_q <= mode_w;
                    err_q  <= 1'b0;
                    if (r > HALF_PI_R || r < -HALF_PI_R) begin
                        ang_q  <= (r > HALF_PI_R) ? WIDTH'(r - PI_R) : WIDTH'(r + PI_R);
                        x_q    <= sat_neg(x_w);
                        y_q    <= sat_neg(y_w);
                        flip_q <= 1'b1;
                    end else begin
                        ang_q  <= r[WIDTH-1:0];
                        x_q    <= x_w;
                        y_q    <= y_w;
                        flip_q <= 1'b0;
                    end
                end
                LCHK: begin
                    mode_q <= mode_w;
                    x_q    <= x_w;
                    y_q    <= y_w;
                    flip_q <= 1'b0;
`ifdef CORDIC_LINEAR_RANGE_CHECK_EN
                    if (sr > ONE_R) begin
                        ang_q <= WIDTH'(ONE_R);
                        err_q <= 1'b1;
                    end else if (sr < -ONE_R) begin
                        ang_q <= WIDTH'(-ONE_R);
                        err_q <= 1'b1;
                    end else begin
                        ang_q <= sr[WIDTH-1:0];
                        err_q <= 1'b0;
                    end
`else
                    ang_q <= sr[WIDTH-1:0];
                    err_q <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_mode  = mode_q;
    assign bus.out_x     = x_q;
    assign bus.out_y     = y_q;
    assign bus.out_angle = ang_q;
    assign bus.out_flip  = flip_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_cordic_angle_reducer.sv
// Directed vector bench for cordic_angle_reducer: table of hand-computed results plus
// stall and mid-operation reset sequences.
module tb_cordic_angle_reducer;
    localparam int C = 0;
    localparam int L = 1;
`ifdef CORDIC_LINEAR_RANGE_CHECK_EN
    localparam int LZ_POS  = 65536;
    localparam int LZ_NEG  = -65536;
    localparam int LZ_N1   = -65536;
    localparam int LERR    = 1;
`else
    localparam int LZ_POS  = 131072;
    localparam int LZ_NEG  = -131072;
    localparam int LZ_N1   = -65537;
    localparam int LERR    = 0;
`endif

    typedef struct {
        int mode;
        int x, y, z;
        int ex, ey, ez;
        int ef, ee;
        int lat;
    } vec_t;

    logic clock;
    logic reset_n;
    int   total;
    int   bad;
    vec_t vecs[$];

    cordic_angle_reducer_if #(.WIDTH(32)) bus();

    cordic_angle_reducer #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(int mode, int x, int y, int z, int ex, int ey, int ez,
                                int ef, int ee, int lat);
        vec_t v;
        v.mode = mode; v.x = x; v.y = y; v.z = z;
        v.ex = ex; v.ey = ey; v.ez = ez; v.ef = ef; v.ee = ee; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d (0x%08h) required=%0d (0x%08h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clock); #1; n++;
        end
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_mode  = 2'(v.mode);
        bus.in_x     = v.x;
        bus.in_y     = v.y;
        bus.in_angle = v.z;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        bus.in_x     = 32'hDEADBEEF;
        bus.in_y     = 32'hDEADBEEF;
        bus.in_angle = 32'hDEADBEEF;
        bus.in_mode  = 2'b10;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clock); #1; n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(v.lat));
        check({tag, "_mode"},  32'(bus.out_mode), 32'(v.mode));
        check({tag, "_x"},     bus.out_x, v.ex);
        check({tag, "_y"},     bus.out_y, v.ey);
        check({tag, "_angle"}, bus.out_angle, v.ez);
        check({tag, "_flip"},  32'(bus.out_flip), 32'(v.ef));
        check({tag, "_err"},   32'(bus.out_err), 32'(v.ee));
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;

        vecs.push_back(mk(C, 65536, 0, 154415, -65536, 0, -51472, 1, 0, 15));
        vecs.push_back(mk(C, 100, 200, 458752, 100, 200, 46978, 0, 0, 15));
        vecs.push_back(mk(C, 100, 200, -458752, 100, 200, -46978, 0, 0, 15));
        vecs.push_back(mk(C, 32'h80000000, 65536, -205887, 32'h7FFFFFFF, -65536, 0, 1, 0, 15));
        vecs.push_back(mk(C, 3, 5, 205887, -3, -5, 0, 1, 0, 15));
        vecs.push_back(mk(C, 7, -9, 102944, 7, -9, 102944, 0, 0, 15));
        vecs.push_back(mk(C, 7, -9, 102945, -7, 9, -102942, 1, 0, 15));
        vecs.push_back(mk(C, 7, -9, -102945, -7, 9, 102942, 1, 0, 15));
        vecs.push_back(mk(C, 1, 2, 32'h80000000, 1, 2, -82238, 0, 0, 15));
        vecs.push_back(mk(C, 1, 2, 32'h7FFFFFFF, 1, 2, 82237, 0, 0, 15));
        vecs.push_back(mk(C, 1, 2, 411774, 1, 2, 0, 0, 0, 15));
        vecs.push_back(mk(C, 1, 2, 617661, -1, -2, 0, 1, 0, 15));
        vecs.push_back(mk(L, 11, 22, 131072, 11, 22, LZ_POS, 0, LERR, 1));
        vecs.push_back(mk(L, 11, 22, -131072, 11, 22, LZ_NEG, 0, LERR, 1));
        vecs.push_back(mk(L, 5, 6, 65536, 5, 6, 65536, 0, 0, 1));
        vecs.push_back(mk(3, 5, 6, -1000, 5, 6, -1000, 0, 0, 1));
        vecs.push_back(mk(2, 8, 9, -65537, 8, 9, LZ_N1, 0, LERR, 1));

        bus.in_valid  = 1'b0;
        bus.in_mode   = 2'b00;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_angle  = '0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("rst_in_ready",  32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_x",     bus.out_x, 32'd0);
        check("rst_out_angle", bus.out_angle, 32'd0);
        check("rst_out_flip",  32'(bus.out_flip), 32'd0);
        check("rst_out_err",   32'(bus.out_err), 32'd0);

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], $sformatf("v%0d", i));

        // Stall in DONE with in_valid pulses that must be ignored.
        bus.in_valid = 1'b1;
        bus.in_mode  = 2'b00;
        bus.in_x     = 65536;
        bus.in_y     = 0;
        bus.in_angle = 154415;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clock); #1; n++;
        end
        check("stall_latency", 32'(n), 32'd15);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_mode  = 2'b01;
            bus.in_x     = 32'(c + 1);
            bus.in_angle = 32'(c + 5);
            @(posedge clock); #1;
            check($sformatf("stall%0d_valid", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("stall%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
            check($sformatf("stall%0d_x", c), bus.out_x, -65536);
            check($sformatf("stall%0d_angle", c), bus.out_angle, -51472);
            check($sformatf("stall%0d_flip", c), 32'(bus.out_flip), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        check("stall_release_valid", 32'(bus.out_valid), 32'd0);
        check("stall_release_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) @(posedge clock);
        #1;
        check("stall_no_ghost_valid", 32'(bus.out_valid), 32'd0);
        check("stall_no_ghost_ready", 32'(bus.in_ready), 32'd1);
        run_vec(vecs[1], "after_stall");

        // Asynchronous reset part-way through REDUCE.
        bus.in_valid = 1'b1;
        bus.in_mode  = 2'b00;
        bus.in_x     = 100;
        bus.in_y     = 200;
        bus.in_angle = 458752;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_x",     bus.out_x, 32'd0);
        check("arst_out_y",     bus.out_y, 32'd0);
        check("arst_out_angle", bus.out_angle, 32'd0);
        check("arst_out_mode",  32'(bus.out_mode), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("arst_in_ready_after", 32'(bus.in_ready), 32'd1);
        check("arst_valid_after",    32'(bus.out_valid), 32'd0);
        run_vec(vecs[0], "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
